// File: rtl/uart_rx_sipo_framer.sv
// Receive-side serial-to-parallel framer: assembles a character from sampler strobes,
// checks parity and stop bit, and presents it on a valid/ready register with overrun.
module uart_rx_sipo_framer #(
    parameter int DATA_W     = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              shift,
    input  logic              data_in,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              parity_err,
    output logic              framing_err,
    output logic              overrun,
    output logic              busy
);
    // state  | meaning
    // IDLE   | waiting for a validated start bit
    // DATA   | shifting in DATA_W data bits
    // PARITY | next shift samples the parity bit
    // STOP   | next shift samples the stop bit and completes the frame

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              par_run;
    logic              parity_bad;
    logic              out_free;
    logic              complete;
    logic              load;
    logic              drop;

    assign out_free = ~out_valid | out_ready;
    // start always wins over a coincident shift, so it also suppresses completion
    assign complete = (state == STOP) & shift & ~start;
    assign load     = complete & out_free;
    assign drop     = complete & ~out_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            par_run     <= 1'b0;
            parity_bad  <= 1'b0;
            busy        <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (start) begin
                state      <= DATA;
                sreg       <= '0;
                bit_cnt    <= '0;
                par_run    <= 1'b0;
                parity_bad <= 1'b0;
                busy       <= 1'b1;
            end else if (shift) begin
                case (state)
                    IDLE: begin
                    end
                    DATA: begin
                        if (LSB_FIRST)
                            sreg <= {data_in, sreg[DATA_W-1:1]};
                        else
                            sreg <= {sreg[DATA_W-2:0], data_in};
                        bit_cnt <= bit_cnt + 1'b1;
                        par_run <= par_run ^ data_in;
                        if (bit_cnt == CNT_W'(DATA_W - 1))
                            state <= PARITY_EN ? PARITY : STOP;
                    end
                    PARITY: begin
                        parity_bad <= par_run ^ data_in ^ PARITY_ODD;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            if (load) begin
                out_data    <= sreg;
                parity_err  <= PARITY_EN & parity_bad;
                framing_err <= ~data_in;
                out_valid   <= 1'b1;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_sipo_framer.sv
// Bench for uart_rx_sipo_framer: five configurations share one stimulus stream and are
// compared every cycle against a bit-list reference model, plus directed frame checks.
module tb_uart_rx_sipo_framer;
    localparam int N = 5;

    logic clk = 1'b0;
    logic reset, start, shift, data_in, out_ready, err_clr;
    always #5 clk = ~clk;

    // per-instance configuration: width, lsb-first, parity enable, odd parity
    int cw [N] = '{8, 8, 7, 8, 8};
    int lsb[N] = '{1, 0, 0, 1, 1};
    int pe [N] = '{0, 0, 0, 1, 1};
    int po [N] = '{0, 0, 0, 0, 1};

    logic [7:0]   data0, data1, data3, data4;
    logic [6:0]   data2;
    logic [N-1:0] vld, perr, ferr, ovr, bsy;
    logic [8:0]   od [N];

    assign od[0] = {1'b0, data0};
    assign od[1] = {1'b0, data1};
    assign od[2] = {2'b0, data2};
    assign od[3] = {1'b0, data3};
    assign od[4] = {1'b0, data4};

    uart_rx_sipo_framer #(.DATA_W(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .reset(reset), .start(start), .shift(shift), .data_in(data_in),
        .out_ready(out_ready), .err_clr(err_clr), .out_data(data0), .out_valid(vld[0]),
        .parity_err(perr[0]), .framing_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));
    uart_rx_sipo_framer #(.DATA_W(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u1 (
        .clk(clk), .reset(reset), .start(start), .shift(shift), .data_in(data_in),
        .out_ready(out_ready), .err_clr(err_clr), .out_data(data1), .out_valid(vld[1]),
        .parity_err(perr[1]), .framing_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));
    uart_rx_sipo_framer #(.DATA_W(7), .LSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
        .clk(clk), .reset(reset), .start(start), .shift(shift), .data_in(data_in),
        .out_ready(out_ready), .err_clr(err_clr), .out_data(data2), .out_valid(vld[2]),
        .parity_err(perr[2]), .framing_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));
    uart_rx_sipo_framer #(.DATA_W(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u3 (
        .clk(clk), .reset(reset), .start(start), .shift(shift), .data_in(data_in),
        .out_ready(out_ready), .err_clr(err_clr), .out_data(data3), .out_valid(vld[3]),
        .parity_err(perr[3]), .framing_err(ferr[3]), .overrun(ovr[3]), .busy(bsy[3]));
    uart_rx_sipo_framer #(.DATA_W(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u4 (
        .clk(clk), .reset(reset), .start(start), .shift(shift), .data_in(data_in),
        .out_ready(out_ready), .err_clr(err_clr), .out_data(data4), .out_valid(vld[4]),
        .parity_err(perr[4]), .framing_err(ferr[4]), .overrun(ovr[4]), .busy(bsy[4]));

    // reference model: list of bits received since the last start
    logic       m_act [N];
    int         m_cnt [N];
    logic [9:0] m_bits[N];
    logic       m_vld [N], m_perr[N], m_ferr[N], m_ovr[N];
    logic [8:0] m_data[N];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_cnt[i] = 0; m_bits[i] = '0; m_vld[i] = 0;
            m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0; m_data[i] = '0;
        end
    endtask

    task automatic model_step(input logic st, sh, d, rdy, clr);
        for (int i = 0; i < N; i++) begin
            logic       free, loaded, dropped;
            int         ones;
            logic [8:0] w;
            free = !m_vld[i] || rdy;
            loaded = 0;
            dropped = 0;
            if (st) begin
                m_act[i] = 1; m_cnt[i] = 0; m_bits[i] = '0;
            end else if (sh && m_act[i]) begin
                if (m_cnt[i] < cw[i] + pe[i]) begin
                    m_bits[i][m_cnt[i]] = d;
                    m_cnt[i]++;
                end else begin
                    m_act[i] = 0;
                    if (free) begin
                        w = '0;
                        ones = 0;
                        for (int k = 0; k < cw[i]; k++) begin
                            if (lsb[i] != 0) w[k] = m_bits[i][k];
                            else w[cw[i]-1-k] = m_bits[i][k];
                            ones += int'(m_bits[i][k]);
                        end
                        if (pe[i] != 0) ones += int'(m_bits[i][cw[i]]);
                        m_data[i] = w;
                        m_perr[i] = (pe[i] != 0) && ((ones % 2) != po[i]);
                        m_ferr[i] = !d;
                        loaded = 1;
                    end else begin
                        dropped = 1;
                    end
                end
            end
            if (loaded) m_vld[i] = 1;
            else if (m_vld[i] && rdy) m_vld[i] = 0;
            if (dropped) m_ovr[i] = 1;
            else if (clr) m_ovr[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.out_valid", i), 9'(vld[i]), 9'(m_vld[i]));
            chk($sformatf("u%0d.out_data", i), od[i], m_data[i]);
            chk($sformatf("u%0d.parity_err", i), 9'(perr[i]), 9'(m_perr[i]));
            chk($sformatf("u%0d.framing_err", i), 9'(ferr[i]), 9'(m_ferr[i]));
            chk($sformatf("u%0d.overrun", i), 9'(ovr[i]), 9'(m_ovr[i]));
            chk($sformatf("u%0d.busy", i), 9'(bsy[i]), 9'(m_act[i]));
        end
    endtask

    task automatic step(input logic st, sh, d, rdy, clr);
        start = st; shift = sh; data_in = d; out_ready = rdy; err_clr = clr;
        @(posedge clk);
        model_step(st, sh, d, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic shift_bits(input logic [9:0] bits, input int n, input logic rdy_body, rdy_last);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1, bits[k], (k == n - 1) ? rdy_last : rdy_body, 1'b0);
            if (k != n - 1) step(1'b0, 1'b0, 1'b0, rdy_body, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [9:0] bits, input int n, input logic rdy_body, rdy_last);
        step(1'b1, 1'b0, 1'b0, rdy_body, 1'b0);
        shift_bits(bits, n, rdy_body, rdy_last);
    endtask

    initial begin
        reset = 1'b1; start = 0; shift = 0; data_in = 1; out_ready = 0; err_clr = 0;
        model_reset();
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check_all();
        reset = 1'b1;

        // 8N1 0xA5, also MSB-first on u1 (bit sequence 1,0,1,0,0,1,0,1)
        send_frame(10'h1A5, 9, 1'b1, 1'b1);
        chk("a5.u0.data", od[0], 9'h0A5);
        chk("a5.u0.valid", 9'(vld[0]), 9'd1);
        chk("a5.u0.busy", 9'(bsy[0]), 9'd0);
        chk("a5.u0.ferr", 9'(ferr[0]), 9'd0);
        chk("a5.u1.data", od[1], 9'h0A5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5.u0.valid_drop", 9'(vld[0]), 9'd0);

        // 7-bit MSB-first: 1,1,0,0,0,0,1 -> 0x61
        send_frame(10'h0C3, 8, 1'b1, 1'b1);
        chk("w7.u2.data", od[2], 9'h061);
        chk("w7.u2.valid", 9'(vld[2]), 9'd1);

        // parity on data 0x03
        send_frame(10'h203, 10, 1'b1, 1'b1);
        chk("par0.u3.valid", 9'(vld[3]), 9'd1);
        chk("par0.u3.perr", 9'(perr[3]), 9'd0);
        send_frame(10'h303, 10, 1'b1, 1'b1);
        chk("par1.u3.perr", 9'(perr[3]), 9'd1);
        chk("par1.u3.data", od[3], 9'h003);
        chk("par1.u4.perr", 9'(perr[4]), 9'd0);

        // stop bit sampled low
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(10'h055, 9, 1'b1, 1'b1);
        chk("frm.u0.valid", 9'(vld[0]), 9'd1);
        chk("frm.u0.data", od[0], 9'h055);
        chk("frm.u0.ferr", 9'(ferr[0]), 9'd1);

        // overrun, err_clr, back-to-back load on handshake
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(10'h111, 9, 1'b0, 1'b0);
        send_frame(10'h122, 9, 1'b0, 1'b0);
        chk("ovr.u0.data", od[0], 9'h011);
        chk("ovr.u0.overrun", 9'(ovr[0]), 9'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr.u0.valid_drop", 9'(vld[0]), 9'd0);
        chk("ovr.u0.sticky", 9'(ovr[0]), 9'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr.u0.cleared", 9'(ovr[0]), 9'd0);
        send_frame(10'h144, 9, 1'b0, 1'b0);
        send_frame(10'h133, 9, 1'b0, 1'b1);
        chk("b2b.u0.valid", 9'(vld[0]), 9'd1);
        chk("b2b.u0.data", od[0], 9'h033);
        chk("b2b.u0.overrun", 9'(ovr[0]), 9'd0);

        // abort after 3 bits, then a full 0x0F frame
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        shift_bits(10'h005, 3, 1'b1, 1'b1);
        send_frame(10'h10F, 9, 1'b1, 1'b1);
        chk("abort.u0.data", od[0], 9'h00F);
        chk("abort.u0.ferr", 9'(ferr[0]), 9'd0);
        chk("abort.u0.overrun", 9'(ovr[0]), 9'd0);

        // asynchronous reset mid-DATA with flags set
        send_frame(10'h0AA, 9, 1'b0, 1'b0);
        send_frame(10'h1BB, 9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_bits(10'h3FF, 3, 1'b0, 1'b0);
        chk("rst.pre.busy", 9'(bsy[0]), 9'd1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst.u0.busy", 9'(bsy[0]), 9'd0);
        chk("rst.u0.valid", 9'(vld[0]), 9'd0);
        chk("rst.u0.overrun", 9'(ovr[0]), 9'd0);
        chk("rst.u0.ferr", 9'(ferr[0]), 9'd0);
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // start and shift together: shift ignored
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("ss.u0.bit_cnt", 9'(u0.bit_cnt), 9'd0);
        shift_bits(10'h15A, 9, 1'b1, 1'b1);
        chk("ss.u0.data", od[0], 9'h05A);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
